ele_con_frame_rx: RTL and testbench
===================================

# ele_con_frame_rx

Receive-side counterpart of the elevator status link. Samples a UART line, assembles 15-byte frames into a 120-bit Hamming-protected codeword, then decodes eight Hamming(15,11) blocks sequentially. Publishes the recovered 57-bit elevator status (hall buttons, per-car internal buttons, floor, direction, door) as registered fields with a one-cycle valid strobe. Sits on the display/monitor side of the link, fed directly by the serial pin.

## Interface
- CLKFRQ, 100000000, clock frequency in Hz
- BAUDRATE, 9600, line rate; BIT_CYCLES = CLKFRQ/BAUDRATE (integer division)
- GAP_BITS, 20, idle bit-times after a byte that abort a partial frame
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rx  in  1  asynchronous serial line, idle high, 8N1, LSB first
- realFloorButton  out  12  hall buttons
- internalButton1/2/3  out  9 each  car internal buttons
- floor1/2/3  out  3 each  car floor
- direction1/2/3  out  2 each  car direction
- doorState1/2/3  out  1 each  door state
- frame_valid  out  1  one-cycle pulse: fields updated this cycle
- frame_error  out  1  one-cycle pulse: frame discarded (bad stop bit)
- err_blocks  out  4  blocks with nonzero syndrome in last valid frame (0..8)

## Operation
- Byte receiver: rx through 2-flop synchronizer; falling edge in IDLE starts bit counter; start bit re-checked at BIT_CYCLES/2, if high return to IDLE (glitch); data bits sampled at mid-bit; stop bit sampled at mid-bit; byte_done pulses at stop-bit sample with stop_ok.
- Frame assembly: byte index k = 0..14. Byte k bit j → codeword bit 119−8k−j.
- stop_ok=0 on any byte: frame_error pulse, k←0, partial frame dropped.
- Gap timer: counts cycles since last byte_done while k≠0; reaching GAP_BITS×BIT_CYCLES → k←0, no error pulse.
- k=14 byte_done: codeword latched, k←0, decoder starts; receiver keeps running (next frame may begin during decode).
- Codeword layout: block b (0..7) = cw[15b+14:15b]; position p (1..15) = cw[15b+p−1]; parity at p=1,2,4,8; data bits d[11b+i], i=0..10, at p=3,5,6,7,9,10,11,12,13,14,15 in order.
- Per block: syndrome = XOR of positions p with bit set; nonzero syndrome s ≤15 flips position s, increments error count.
- Payload = d[56:0]; d[87:57] ignored. payload[56:45]=realFloorButton; car1: [44:36] internal, [35:33] floor, [32:31] direction, [30] door; car2: [29:21],[20:18],[17:16],[15]; car3: [14:6],[5:3],[2:1],[0].
- Decoder FSM: IDLE → DEC (b=0..7, one block/cycle) → PUB (fields, err_blocks written, frame_valid=1) → IDLE.
- New codeword arriving while decoder busy: impossible at ≥1 byte-time per byte; no queueing required.

## Timing
- Reset: all outputs 0; receiver IDLE; k=0; decoder IDLE; codeword register 0.
- Reset mid-byte or mid-frame: all progress discarded, no pulses.
- frame_valid asserts 10 cycles after the final byte_done (1 latch, 8 DEC, 1 PUB); fields stable until next frame_valid.
- frame_valid and frame_error never in the same cycle.
- Byte_done ≈ 9.5 bit-times after start-bit falling edge.

## Configuration
- ELE_CON_RX_ECC_EN defined: single-error correction per block; err_blocks counts nonzero syndromes.
- Undefined: data bits extracted raw, no correction, err_blocks always 0; FSM and latency unchanged.

## Structure
- Package ele_con_pkg: FRAME_BYTES=15, CW_BITS=120, PAYLOAD_BITS=57, BLOCKS=8, Hamming position/data-index constants, payload field offsets.
- Sub-module uart_byte_rx (synchronizer, start/data/stop sampling, byte_done, stop_ok); framing, gap timer, decoder FSM in top.

## Test plan
- Clean frame, payload 57'h1_0000_0000_0000_01 → frame_valid after 10 cycles, realFloorButton=12'h800, doorState3=1, others 0, err_blocks=0.
- Single bit flip in block 3 position 6 (ECC_EN) → fields equal clean payload, err_blocks=1; without macro → corrupted field bit, err_blocks=0.
- Byte 7 with stop bit 0 → frame_error pulse, no frame_valid; following clean frame decodes normally.
- Send 5 bytes, idle 25 bit-times, then full frame → only one frame_valid, correct fields.
- Half-bit low glitch on idle rx → no byte accepted, k stays 0.
- Assert reset during byte 10 → outputs 0, no pulses; next complete frame decodes correctly.

Source files
------------

// File: rtl/ele_con_frame_rx_pkg.sv
// ele_con_pkg: frame geometry, Hamming(15,11) helpers and payload
// layout shared by the elevator status link receiver.
package ele_con_pkg;

  localparam int FRAME_BYTES  = 15;
  localparam int CW_BITS      = 120;
  localparam int PAYLOAD_BITS = 57;
  localparam int BLOCKS       = 8;
  localparam int BLK_BITS     = 15;
  localparam int BLK_DATA     = 11;

  // zero-based codeword positions of data bits 0..10 (p=3,5,6,7,9..15)
  localparam logic [43:0] DIDX = {
    4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9,
    4'd8, 4'd6, 4'd5, 4'd4, 4'd2
  };

  localparam int RFB_BITS = 12;
  localparam int CAR_BITS = 15;
  localparam int RFB_LSB  = 45;
  localparam int CAR1_LSB = 30;
  localparam int CAR2_LSB = 15;
  localparam int CAR3_LSB = 0;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    D_IDLE, D_DEC, D_PUB
  } dec_state_t;

  typedef struct packed {
    logic [8:0] internal;
    logic [2:0] floor;
    logic [1:0] dir;
    logic       door;
  } car_t;

  typedef struct packed {
    logic [11:0] rfb;
    car_t        car1;
    car_t        car2;
    car_t        car3;
  } status_t;

  function automatic logic [3:0] ham_syndrome(input logic [14:0] blk);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 15; i++)
      if (blk[i]) s = s ^ 4'(i + 1);
    return s;
  endfunction

  function automatic logic [10:0] ham_data(input logic [14:0] blk);
    logic [10:0] d;
    d = '0;
    for (int i = 0; i < 11; i++)
      d[i] = blk[DIDX[4*i +: 4]];
    return d;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/ele_con_frame_rx_if.sv
// Serial line in, decoded elevator status out.
// slave = receiver side, master = line driver / status consumer.
interface ele_con_frame_rx_if;

  logic       rx;
  logic [11:0] realFloorButton;
  logic [8:0] internalButton1;
  logic [8:0] internalButton2;
  logic [8:0] internalButton3;
  logic [2:0] floor1;
  logic [2:0] floor2;
  logic [2:0] floor3;
  logic [1:0] direction1;
  logic [1:0] direction2;
  logic [1:0] direction3;
  logic       doorState1;
  logic       doorState2;
  logic       doorState3;
  logic       frame_valid;
  logic       frame_error;
  logic [3:0] err_blocks;

  modport master (
    output rx,
    input  realFloorButton,
    input  internalButton1, internalButton2, internalButton3,
    input  floor1, floor2, floor3,
    input  direction1, direction2, direction3,
    input  doorState1, doorState2, doorState3,
    input  frame_valid, frame_error, err_blocks
  );

  modport slave (
    input  rx,
    output realFloorButton,
    output internalButton1, internalButton2, internalButton3,
    output floor1, floor2, floor3,
    output direction1, direction2, direction3,
    output doorState1, doorState2, doorState3,
    output frame_valid, frame_error, err_blocks
  );

endinterface

// File: rtl/ele_con_frame_rx_uart_byte_rx.sv
// uart_byte_rx: 8N1 byte receiver with 2-flop synchronizer,
// glitch-rejecting start check and mid-bit sampling.
module uart_byte_rx
  import ele_con_pkg::*;
#(
  parameter int BIT_CYCLES = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic       byte_done_o,
  output logic       stop_ok_o,
  output logic [7:0] data_o
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYCLES - 1);

  // [0],[1] synchronizer, [2] previous synchronized level
  logic [2:0]    sync_q;
  rx_state_t     st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          done_q;
  logic          ok_q;
  logic [7:0]    data_q;
  logic          fall;

  assign fall = sync_q[2] & ~sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 3'b111;
      st_q   <= R_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      data_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], rx_i};
      done_q <= 1'b0;
      unique case (st_q)
        R_IDLE: begin
          if (fall) begin
            st_q  <= R_START;
            cnt_q <= '0;
          end
        end
        R_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            bit_q <= '0;
            st_q  <= sync_q[1] ? R_IDLE : R_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            sh_q  <= {sync_q[1], sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) st_q <= R_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
            ok_q   <= sync_q[1];
            data_q <= sh_q;
            st_q   <= R_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: st_q <= R_IDLE;
      endcase
    end
  end

  assign byte_done_o = done_q;
  assign stop_ok_o   = ok_q;
  assign data_o      = data_q;

endmodule

// File: rtl/ele_con_frame_rx.sv
// ele_con_frame_rx: UART frame assembly and Hamming(15,11) decode of the
// elevator status link. ELE_CON_RX_ECC_EN enables per-block correction.
module ele_con_frame_rx
  import ele_con_pkg::*;
#(
  parameter int CLKFRQ   = 100000000,
  parameter int BAUDRATE = 9600,
  parameter int GAP_BITS = 20
) (
  input logic clk,
  input logic reset,
  ele_con_frame_rx_if.slave bus
);

  localparam int BIT_CYCLES = CLKFRQ / BAUDRATE;
  localparam int GAP_CYC    = GAP_BITS * BIT_CYCLES;
  localparam int GW         = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_M1 = GW'(GAP_CYC - 1);
  localparam logic [3:0] K_LAST = 4'(FRAME_BYTES - 1);

  logic             byte_done;
  logic             stop_ok;
  logic [7:0]       rx_byte;
  logic             cw_load;

  logic [3:0]         k_q;
  logic [CW_BITS-9:0] asm_q;
  logic [GW-1:0]      gap_q;
  logic [CW_BITS-1:0] cw_q;
  logic               fe_q;

  dec_state_t              dst_q;
  logic [2:0]              blk_q;
  logic [PAYLOAD_BITS-1:0] d_q;
  logic [PAYLOAD_BITS-1:0] d_d;
  logic [3:0]              nerr_q;
  logic [3:0]              err_blocks_q;
  logic                    fv_q;
  status_t                 status_q;

  logic [6:0]  base;
  logic [6:0]  didx;
  logic [14:0] blk_raw;
  logic [14:0] blk_fix;
  logic [10:0] dbits;
  logic        blk_err;
`ifdef ELE_CON_RX_ECC_EN
  logic [3:0]  syn;
`endif

  uart_byte_rx #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (bus.rx),
    .byte_done_o (byte_done),
    .stop_ok_o   (stop_ok),
    .data_o      (rx_byte)
  );

  assign cw_load = byte_done & stop_ok & (k_q == K_LAST);

  // Bytes shift in MSB-first with bit order reversed, so byte 0 bit 0
  // lands on cw[119] once the frame is complete.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q   <= '0;
      asm_q <= '0;
      gap_q <= '0;
      cw_q  <= '0;
      fe_q  <= 1'b0;
    end else begin
      fe_q <= 1'b0;
      if (byte_done) begin
        gap_q <= '0;
        if (!stop_ok) begin
          fe_q <= 1'b1;
          k_q  <= '0;
        end else if (k_q == K_LAST) begin
          cw_q <= {asm_q, rev8(rx_byte)};
          k_q  <= '0;
        end else begin
          asm_q <= {asm_q[CW_BITS-17:0], rev8(rx_byte)};
          k_q   <= k_q + 4'd1;
        end
      end else if (k_q != 4'd0) begin
        if (gap_q == GAP_M1) begin
          k_q   <= '0;
          gap_q <= '0;
        end else begin
          gap_q <= gap_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    base    = 7'(BLK_BITS * int'(blk_q));
    blk_raw = cw_q[base +: BLK_BITS];
    blk_fix = blk_raw;
    blk_err = 1'b0;
`ifdef ELE_CON_RX_ECC_EN
    syn = ham_syndrome(blk_raw);
    if (syn != 4'd0) begin
      blk_err = 1'b1;
      blk_fix[syn - 4'd1] = ~blk_raw[syn - 4'd1];
    end
`endif
    dbits = ham_data(blk_fix);
    d_d   = d_q;
    didx  = '0;
    // data bits past the payload (d[87:57]) are dropped
    for (int i = 0; i < BLK_DATA; i++) begin
      didx = 7'(BLK_DATA * int'(blk_q) + i);
      if (didx < 7'(PAYLOAD_BITS)) d_d[didx[5:0]] = dbits[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dst_q        <= D_IDLE;
      blk_q        <= '0;
      d_q          <= '0;
      nerr_q       <= '0;
      err_blocks_q <= '0;
      fv_q         <= 1'b0;
      status_q     <= '0;
    end else begin
      fv_q <= 1'b0;
      unique case (dst_q)
        D_IDLE: begin
          if (cw_load) begin
            dst_q  <= D_DEC;
            blk_q  <= '0;
            nerr_q <= '0;
          end
        end
        D_DEC: begin
          d_q    <= d_d;
          nerr_q <= nerr_q + {3'b000, blk_err};
          blk_q  <= blk_q + 3'd1;
          if (blk_q == 3'(BLOCKS - 1)) dst_q <= D_PUB;
        end
        D_PUB: begin
          status_q.rfb  <= d_q[RFB_LSB +: RFB_BITS];
          status_q.car1 <= car_t'(d_q[CAR1_LSB +: CAR_BITS]);
          status_q.car2 <= car_t'(d_q[CAR2_LSB +: CAR_BITS]);
          status_q.car3 <= car_t'(d_q[CAR3_LSB +: CAR_BITS]);
          err_blocks_q  <= nerr_q;
          fv_q          <= 1'b1;
          dst_q         <= D_IDLE;
        end
        default: dst_q <= D_IDLE;
      endcase
    end
  end

  assign bus.realFloorButton = status_q.rfb;
  assign bus.internalButton1 = status_q.car1.internal;
  assign bus.internalButton2 = status_q.car2.internal;
  assign bus.internalButton3 = status_q.car3.internal;
  assign bus.floor1          = status_q.car1.floor;
  assign bus.floor2          = status_q.car2.floor;
  assign bus.floor3          = status_q.car3.floor;
  assign bus.direction1      = status_q.car1.dir;
  assign bus.direction2      = status_q.car2.dir;
  assign bus.direction3      = status_q.car3.dir;
  assign bus.doorState1      = status_q.car1.door;
  assign bus.doorState2      = status_q.car2.door;
  assign bus.doorState3      = status_q.car3.door;
  assign bus.frame_valid     = fv_q;
  assign bus.frame_error     = fe_q;
  assign bus.err_blocks      = err_blocks_q;

endmodule

// File: tb/tb_ele_con_frame_rx.sv
// tb_ele_con_frame_rx: randomized serial frames checked against a
// Hamming encoder / payload model kept in the bench.
module tb_ele_con_frame_rx;

  localparam int CLKFRQ   = 800;
  localparam int BAUDRATE = 100;
  localparam int GAP_BITS = 20;
  localparam int BC       = CLKFRQ / BAUDRATE;
`ifdef ELE_CON_RX_ECC_EN
  localparam bit ECC = 1'b1;
`else
  localparam bit ECC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   fv_cnt = 0;
  int   fe_cnt = 0;
  int   both_cnt = 0;
  int   fv_cyc = 0;
  int   last_start = 0;
  logic [56:0] got_pl = '0;
  logic [3:0]  got_err = '0;

  ele_con_frame_rx_if bus ();

  ele_con_frame_rx #(
    .CLKFRQ   (CLKFRQ),
    .BAUDRATE (BAUDRATE),
    .GAP_BITS (GAP_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [56:0] obs();
    return {bus.realFloorButton,
            bus.internalButton1, bus.floor1, bus.direction1, bus.doorState1,
            bus.internalButton2, bus.floor2, bus.direction2, bus.doorState2,
            bus.internalButton3, bus.floor3, bus.direction3, bus.doorState3};
  endfunction

  always @(negedge clk) begin
    if (bus.frame_valid) begin
      fv_cnt  = fv_cnt + 1;
      fv_cyc  = cyc;
      got_pl  = obs();
      got_err = bus.err_blocks;
    end
    if (bus.frame_error) fe_cnt = fe_cnt + 1;
    if (bus.frame_valid && bus.frame_error) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hamming(15,11) encoder: data fills non-power-of-two positions,
  // each parity bit makes its covered positions XOR to zero.
  function automatic logic [119:0] encode(input logic [87:0] d);
    logic [119:0] cw;
    logic [15:0]  pos;
    logic         par;
    int           di;
    cw = '0;
    for (int b = 0; b < 8; b++) begin
      pos = '0;
      di  = 0;
      for (int p = 1; p <= 15; p++)
        if ((p & (p - 1)) != 0) begin
          pos[p] = d[11*b + di];
          di++;
        end
      for (int k = 0; k < 4; k++) begin
        par = 1'b0;
        for (int p = 1; p <= 15; p++)
          if ((p & (1 << k)) != 0) par = par ^ pos[p];
        pos[1 << k] = par;
      end
      for (int p = 1; p <= 15; p++) cw[15*b + p - 1] = pos[p];
    end
    return cw;
  endfunction

  function automatic int data_rank(input int p);
    int r;
    if ((p & (p - 1)) == 0) return -1;
    r = 0;
    for (int q = 1; q < p; q++)
      if ((q & (q - 1)) != 0) r++;
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop,
                           input int idle_bits);
    @(posedge clk); #1; bus.rx = 1'b0; last_start = cyc;
    repeat (BC - 1) @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1; bus.rx = b[j];
      repeat (BC - 1) @(posedge clk);
    end
    @(posedge clk); #1; bus.rx = stop;
    repeat (BC - 1) @(posedge clk);
    @(posedge clk); #1; bus.rx = 1'b1;
    repeat (idle_bits * BC) @(posedge clk);
  endtask

  task automatic send_frame(input logic [119:0] cw, input int nbytes,
                            input int bad_idx, input int maxgap,
                            input int final_idle);
    logic [7:0] b;
    int         g;
    for (int k = 0; k < nbytes; k++) begin
      for (int j = 0; j < 8; j++) b[j] = cw[119 - 8*k - j];
      g = (k == nbytes - 1) ? final_idle : int'($urandom_range(0, maxgap));
      send_byte(b, (k != bad_idx), g);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [119:0] cw,
                              input logic [56:0] exp_pl,
                              input logic [3:0] exp_err, input int maxgap);
    int fv0;
    int fe0;
    int lat;
    fv0 = fv_cnt;
    fe0 = fe_cnt;
    send_frame(cw, 15, -1, maxgap, 2);
    repeat (2 * BC) @(posedge clk);
    chk({tag, "_nvalid"}, 64'(fv_cnt - fv0), 64'd1);
    chk({tag, "_nerror"}, 64'(fe_cnt - fe0), 64'd0);
    chk({tag, "_payload"}, 64'(got_pl), 64'(exp_pl));
    chk({tag, "_errblk"}, 64'(got_err), 64'(exp_err));
    lat = fv_cyc - last_start;
    chk($sformatf("%s_latency%0d", tag, lat),
        64'(lat >= 9*BC + BC/2 + 10 && lat <= 9*BC + BC/2 + 13), 64'd1);
    @(negedge clk);
    chk({tag, "_hold"}, 64'(obs()), 64'(exp_pl));
  endtask

  logic [87:0]  d;
  logic [87:0]  dc;
  logic [119:0] cw;
  logic [56:0]  pl0;
  logic [56:0]  exp_pl;
  int           nflip;
  int           p;
  int           r;
  int           fv0;
  int           fe0;

  initial begin
    bus.rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_payload", 64'(obs()), 64'd0);
    chk("rst_errblk", 64'(bus.err_blocks), 64'd0);
    chk("rst_valid", 64'(bus.frame_valid), 64'd0);
    chk("rst_error", 64'(bus.frame_error), 64'd0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (2 * BC) @(posedge clk);

    pl0 = 57'h1_0000_0000_0000_01;
    cw  = encode({31'd0, pl0});
    expect_frame("clean", cw, pl0, 4'd0, 0);
    chk("clean_rfb", 64'(bus.realFloorButton), 64'h800);
    chk("clean_door3", 64'(bus.doorState3), 64'd1);

    cw[15*3 + 6 - 1] = ~cw[15*3 + 6 - 1];
    exp_pl = ECC ? pl0 : (pl0 ^ (57'd1 << (11*3 + data_rank(6))));
    expect_frame("flip_b3p6", cw, exp_pl, ECC ? 4'd1 : 4'd0, 1);

    fv0 = fv_cnt;
    fe0 = fe_cnt;
    d = {24'($urandom), $urandom, $urandom};
    send_frame(encode(d), 8, 7, 1, 3);
    repeat (2 * BC) @(posedge clk);
    chk("badstop_nerror", 64'(fe_cnt - fe0), 64'd1);
    chk("badstop_nvalid", 64'(fv_cnt - fv0), 64'd0);
    chk("badstop_hold", 64'(obs()), 64'(exp_pl));
    d = {24'($urandom), $urandom, $urandom};
    expect_frame("after_bad", encode(d), d[56:0], 4'd0, 2);

    fv0 = fv_cnt;
    d = {24'($urandom), $urandom, $urandom};
    send_frame(encode(d), 5, -1, 0, 25);
    d = {24'($urandom), $urandom, $urandom};
    expect_frame("gap_abort", encode(d), d[56:0], 4'd0, 2);
    chk("gap_total_valid", 64'(fv_cnt - fv0), 64'd1);

    fe0 = fe_cnt;
    @(posedge clk); #1; bus.rx = 1'b0;
    repeat (BC/2 - 1) @(posedge clk);
    #1; bus.rx = 1'b1;
    repeat (3 * BC) @(posedge clk);
    d = {24'($urandom), $urandom, $urandom};
    expect_frame("glitch", encode(d), d[56:0], 4'd0, 1);
    chk("glitch_nerror", 64'(fe_cnt - fe0), 64'd0);

    fv0 = fv_cnt;
    fe0 = fe_cnt;
    d = {24'($urandom), $urandom, $urandom};
    send_frame(encode(d), 10, -1, 1, 0);
    @(posedge clk); #1; bus.rx = 1'b0;
    repeat (3 * BC) @(posedge clk);
    #1; reset = 1'b1; bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_payload", 64'(obs()), 64'd0);
    chk("midrst_errblk", 64'(bus.err_blocks), 64'd0);
    @(posedge clk); #1; reset = 1'b0;
    repeat (25 * BC) @(posedge clk);
    chk("midrst_nopulse", 64'((fv_cnt - fv0) + (fe_cnt - fe0)), 64'd0);
    d = {24'($urandom), $urandom, $urandom};
    expect_frame("after_rst", encode(d), d[56:0], 4'd0, 1);

    for (int t = 0; t < 8; t++) begin
      d  = {24'($urandom), $urandom, $urandom};
      cw = encode(d);
      dc = d;
      nflip = 0;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 2) == 0) begin
          p = int'($urandom_range(1, 15));
          cw[15*b + p - 1] = ~cw[15*b + p - 1];
          nflip++;
          r = data_rank(p);
          if (r >= 0) dc[11*b + r] = ~dc[11*b + r];
        end
      expect_frame($sformatf("rand%0d", t), cw,
                   ECC ? d[56:0] : dc[56:0],
                   ECC ? 4'(nflip) : 4'd0, 3);
    end

    chk("valid_error_overlap", 64'(both_cnt), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
